// File: rtl/reservation_station_pkg.sv
// Shared widths, op encodings and entry/CDB types for the arithmetic/branch reservation station.
// Also holds the operand wake-up rule used both at allocation and for stored entries.
package reservation_station_pkg;

    localparam int RS_SIZE = 16;
    localparam int RS_LOG  = 4;
    localparam int ROB_LOG = 4;
    localparam int OP_LOG  = 6;

    localparam logic [OP_LOG-1:0] OP_ADD = 6'd0;
    localparam logic [OP_LOG-1:0] OP_SUB = 6'd1;
    localparam logic [OP_LOG-1:0] OP_AND = 6'd2;
    localparam logic [OP_LOG-1:0] OP_OR  = 6'd3;
    localparam logic [OP_LOG-1:0] OP_XOR = 6'd4;
    localparam logic [OP_LOG-1:0] OP_BEQ = 6'd5;
    localparam logic [OP_LOG-1:0] OP_BNE = 6'd6;

    typedef struct packed {
        logic [31:0]        v;
        logic               r;
        logic [ROB_LOG-1:0] q;
    } opnd_t;

    typedef struct packed {
        logic               valid;
        logic [OP_LOG-1:0]  op;
        opnd_t              j;
        opnd_t              k;
        logic [31:0]        imm;
        logic [31:0]        pc;
        logic [ROB_LOG-1:0] rob_id;
    } rs_entry_t;

    typedef struct packed {
        logic               valid;
        logic [ROB_LOG-1:0] rob_id;
        logic [31:0]        value;
    } cdb_t;

    // LSB wins when both buses match; that only happens for an illegal duplicate tag.
    function automatic opnd_t wake(opnd_t o, cdb_t alu, cdb_t lsb);
        opnd_t w;
        w = o;
        if (!o.r) begin
            if (lsb.valid && lsb.rob_id == o.q) begin
                w.v = lsb.value;
                w.r = 1'b1;
            end else if (alu.valid && alu.rob_id == o.q) begin
                w.v = alu.value;
                w.r = 1'b1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/reservation_station_rs_priority_encoder.sv
// Lowest-set-bit finder: index of the lowest asserted bit of vec, found=0 when vec is zero.
module rs_priority_encoder #(
    parameter int WIDTH = 16,
    parameter int LOG   = 4
) (
    input  logic [WIDTH-1:0] vec,
    output logic [LOG-1:0]   index,
    output logic             found
);

    always_comb begin
        index = '0;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                index = LOG'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Reservation station: buffers renamed ALU/branch micro-ops, wakes operands from the ALU and LSB
// broadcast buses, and dispatches the lowest-index ready entry to the ALU once per cycle.
module reservation_station
    import reservation_station_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               clear,
    input  logic               issue_enable,
    input  logic [OP_LOG-1:0]  issue_op,
    input  logic [31:0]        issue_Vj,
    input  logic               issue_Rj,
    input  logic [ROB_LOG-1:0] issue_Qj,
    input  logic [31:0]        issue_Vk,
    input  logic               issue_Rk,
    input  logic [ROB_LOG-1:0] issue_Qk,
    input  logic [31:0]        issue_Imm,
    input  logic [31:0]        issue_CurPc,
    input  logic [ROB_LOG-1:0] issue_RobId,
    output logic               rs_full,
    input  logic               alu_cdb_valid,
    input  logic [ROB_LOG-1:0] alu_cdb_RobId,
    input  logic [31:0]        alu_cdb_value,
    input  logic               lsb_cdb_valid,
    input  logic [ROB_LOG-1:0] lsb_cdb_RobId,
    input  logic [31:0]        lsb_cdb_value,
    output logic               alu_enable,
    output logic [OP_LOG-1:0]  alu_op,
    output logic [31:0]        alu_Vj,
    output logic [31:0]        alu_Vk,
    output logic [31:0]        alu_Imm,
    output logic [31:0]        alu_CurPc,
    output logic [ROB_LOG-1:0] alu_RobId
);

    rs_entry_t [RS_SIZE-1:0] ent, ent_nxt;
    logic [RS_SIZE-1:0]      free_vec, ready_vec;
    logic [RS_LOG-1:0]       free_idx, ready_idx;
    logic                    free_found, ready_found;
    logic [RS_LOG:0]         cnt_nxt;
    cdb_t                    alu_cdb, lsb_cdb;
    opnd_t                   in_j, in_k;

    assign alu_cdb = '{valid: alu_cdb_valid, rob_id: alu_cdb_RobId, value: alu_cdb_value};
    assign lsb_cdb = '{valid: lsb_cdb_valid, rob_id: lsb_cdb_RobId, value: lsb_cdb_value};
    assign in_j    = '{v: issue_Vj, r: issue_Rj, q: issue_Qj};
    assign in_k    = '{v: issue_Vk, r: issue_Rk, q: issue_Qk};

    // Both vectors come from registered state, so a freshly allocated entry cannot dispatch.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            free_vec[i]  = !ent[i].valid;
            ready_vec[i] = ent[i].valid && ent[i].j.r && ent[i].k.r;
        end
    end

    rs_priority_encoder #(.WIDTH(RS_SIZE), .LOG(RS_LOG)) u_free_enc (
        .vec   (free_vec),
        .index (free_idx),
        .found (free_found)
    );

    rs_priority_encoder #(.WIDTH(RS_SIZE), .LOG(RS_LOG)) u_ready_enc (
        .vec   (ready_vec),
        .index (ready_idx),
        .found (ready_found)
    );

    always_comb begin
        ent_nxt = ent;
        for (int i = 0; i < RS_SIZE; i++) begin
            ent_nxt[i].j = wake(ent[i].j, alu_cdb, lsb_cdb);
            ent_nxt[i].k = wake(ent[i].k, alu_cdb, lsb_cdb);
        end
        if (ready_found)
            ent_nxt[ready_idx].valid = 1'b0;
        // Issuing into a full station drops the op silently.
        if (issue_enable && free_found) begin
            ent_nxt[free_idx].valid  = 1'b1;
            ent_nxt[free_idx].op     = issue_op;
            ent_nxt[free_idx].j      = wake(in_j, alu_cdb, lsb_cdb);
            ent_nxt[free_idx].k      = wake(in_k, alu_cdb, lsb_cdb);
            ent_nxt[free_idx].imm    = issue_Imm;
            ent_nxt[free_idx].pc     = issue_CurPc;
            ent_nxt[free_idx].rob_id = issue_RobId;
        end
        if (clear) begin
            for (int i = 0; i < RS_SIZE; i++)
                ent_nxt[i].valid = 1'b0;
        end
        cnt_nxt = '0;
        for (int i = 0; i < RS_SIZE; i++)
            cnt_nxt = cnt_nxt + {{RS_LOG{1'b0}}, ent_nxt[i].valid};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ent        <= '0;
            rs_full    <= 1'b0;
            alu_enable <= 1'b0;
            alu_op     <= '0;
            alu_Vj     <= '0;
            alu_Vk     <= '0;
            alu_Imm    <= '0;
            alu_CurPc  <= '0;
            alu_RobId  <= '0;
        end else if (rdy) begin
            ent     <= ent_nxt;
            // One slot of slack absorbs the issue already in flight when rs_full rises.
            rs_full <= cnt_nxt >= (RS_LOG+1)'(RS_SIZE - 1);
            if (clear) begin
                alu_enable <= 1'b0;
            end else begin
                alu_enable <= ready_found;
                if (ready_found) begin
                    alu_op    <= ent[ready_idx].op;
                    alu_Vj    <= ent[ready_idx].j.v;
                    alu_Vk    <= ent[ready_idx].k.v;
                    alu_Imm   <= ent[ready_idx].imm;
                    alu_CurPc <= ent[ready_idx].pc;
                    alu_RobId <= ent[ready_idx].rob_id;
                end
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: constant-expectation vector table, directed multi-cycle
// sequences, and randomized traffic checked every cycle against an array-based reference model.
module tb_reservation_station;

    logic        clk = 1'b0;
    logic        rst, rdy, clear;
    logic        issue_enable;
    logic [5:0]  issue_op;
    logic [31:0] issue_Vj, issue_Vk, issue_Imm, issue_CurPc;
    logic        issue_Rj, issue_Rk;
    logic [3:0]  issue_Qj, issue_Qk, issue_RobId;
    logic        rs_full;
    logic        alu_cdb_valid, lsb_cdb_valid;
    logic [3:0]  alu_cdb_RobId, lsb_cdb_RobId;
    logic [31:0] alu_cdb_value, lsb_cdb_value;
    logic        alu_enable;
    logic [5:0]  alu_op;
    logic [31:0] alu_Vj, alu_Vk, alu_Imm, alu_CurPc;
    logic [3:0]  alu_RobId;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    reservation_station dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .issue_enable(issue_enable), .issue_op(issue_op),
        .issue_Vj(issue_Vj), .issue_Rj(issue_Rj), .issue_Qj(issue_Qj),
        .issue_Vk(issue_Vk), .issue_Rk(issue_Rk), .issue_Qk(issue_Qk),
        .issue_Imm(issue_Imm), .issue_CurPc(issue_CurPc), .issue_RobId(issue_RobId),
        .rs_full(rs_full),
        .alu_cdb_valid(alu_cdb_valid), .alu_cdb_RobId(alu_cdb_RobId), .alu_cdb_value(alu_cdb_value),
        .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_RobId(lsb_cdb_RobId), .lsb_cdb_value(lsb_cdb_value),
        .alu_enable(alu_enable), .alu_op(alu_op), .alu_Vj(alu_Vj), .alu_Vk(alu_Vk),
        .alu_Imm(alu_Imm), .alu_CurPc(alu_CurPc), .alu_RobId(alu_RobId)
    );

    // Reference model: a plain array of slots plus the expected registered outputs.
    typedef struct {
        bit        v;
        bit [5:0]  op;
        bit [31:0] vj, vk, imm, pc;
        bit        rj, rk;
        bit [3:0]  qj, qk, rob;
    } ment_t;
    ment_t     m[16];
    bit        e_en, e_full;
    bit [5:0]  e_op;
    bit [31:0] e_vj, e_vk, e_imm, e_pc;
    bit [3:0]  e_rob;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void mwake(inout bit [31:0] v, inout bit r, input bit [3:0] q);
        if (!r) begin
            if (lsb_cdb_valid && lsb_cdb_RobId == q) begin v = lsb_cdb_value; r = 1'b1; end
            else if (alu_cdb_valid && alu_cdb_RobId == q) begin v = alu_cdb_value; r = 1'b1; end
        end
    endfunction

    task automatic model_step();
        int sel, fr, cnt;
        if (rst) begin
            for (int i = 0; i < 16; i++) m[i].v = 1'b0;
            e_en = 0; e_full = 0; e_op = 0; e_vj = 0; e_vk = 0; e_imm = 0; e_pc = 0; e_rob = 0;
            return;
        end
        if (!rdy) return;
        if (clear) begin
            for (int i = 0; i < 16; i++) m[i].v = 1'b0;
            e_en = 0; e_full = 0;
            return;
        end
        sel = -1; fr = -1;
        for (int i = 0; i < 16; i++) begin
            if (sel < 0 && m[i].v && m[i].rj && m[i].rk) sel = i;
            if (fr < 0 && !m[i].v) fr = i;
        end
        e_en = (sel >= 0);
        if (sel >= 0) begin
            e_op = m[sel].op; e_vj = m[sel].vj; e_vk = m[sel].vk;
            e_imm = m[sel].imm; e_pc = m[sel].pc; e_rob = m[sel].rob;
            m[sel].v = 1'b0;
        end
        for (int i = 0; i < 16; i++) begin
            if (m[i].v) begin
                mwake(m[i].vj, m[i].rj, m[i].qj);
                mwake(m[i].vk, m[i].rk, m[i].qk);
            end
        end
        if (issue_enable) begin
            n_tests++;
            if (fr < 0) begin
                n_fail++;
                $display("FAIL overflow: issue accepted with 0 free slots, required at least 1");
            end else begin
                m[fr].v = 1'b1; m[fr].op = issue_op; m[fr].imm = issue_Imm; m[fr].pc = issue_CurPc;
                m[fr].rob = issue_RobId;
                m[fr].vj = issue_Vj; m[fr].rj = issue_Rj; m[fr].qj = issue_Qj;
                m[fr].vk = issue_Vk; m[fr].rk = issue_Rk; m[fr].qk = issue_Qk;
                mwake(m[fr].vj, m[fr].rj, m[fr].qj);
                mwake(m[fr].vk, m[fr].rk, m[fr].qk);
            end
        end
        cnt = 0;
        for (int i = 0; i < 16; i++) cnt += int'(m[i].v);
        e_full = (cnt >= 15);
    endtask

    // Advance one clock with the currently driven inputs, then compare against the model.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("alu_enable", 32'(alu_enable), 32'(e_en));
        chk("rs_full",    32'(rs_full),    32'(e_full));
        chk("alu_op",     32'(alu_op),     32'(e_op));
        chk("alu_Vj",     alu_Vj,          e_vj);
        chk("alu_Vk",     alu_Vk,          e_vk);
        chk("alu_Imm",    alu_Imm,         e_imm);
        chk("alu_CurPc",  alu_CurPc,       e_pc);
        chk("alu_RobId",  32'(alu_RobId),  32'(e_rob));
    endtask

    task automatic idle();
        rst = 0; rdy = 1; clear = 0; issue_enable = 0; alu_cdb_valid = 0; lsb_cdb_valid = 0;
    endtask

    task automatic set_issue(input bit [5:0] op, input bit [31:0] vj, input bit rj, input bit [3:0] qj,
                             input bit [31:0] vk, input bit rk, input bit [3:0] qk, input bit [3:0] rob);
        issue_enable = 1; issue_op = op; issue_Vj = vj; issue_Rj = rj; issue_Qj = qj;
        issue_Vk = vk; issue_Rk = rk; issue_Qk = qk; issue_RobId = rob;
        issue_Imm = 32'h100 + 32'(rob); issue_CurPc = 32'h4000 + 32'(rob) * 4;
    endtask

    typedef struct {
        bit [31:0] vj; bit rj; bit [3:0] qj;
        bit [31:0] vk; bit rk; bit [3:0] qk;
        bit [3:0]  rob;
        bit av; bit [3:0] aid; bit [31:0] aval;
        bit lv; bit [3:0] lid; bit [31:0] lval;
        bit [31:0] xvj, xvk;
    } vec_t;
    vec_t vecs[6];

    initial begin
        // Ready op; same-cycle LSB forward; same-cycle ALU forward; both buses match (LSB wins);
        // ready operand ignores a matching tag; each operand woken by a different bus.
        vecs[0] = '{32'd5,  1, 4'd0, 32'd7,  1, 4'd0, 4'd3, 0, 4'd0, 32'h0,    0, 4'd0, 32'h0,    32'd5,     32'd7};
        vecs[1] = '{32'h22, 1, 4'd0, 32'h0,  0, 4'd4, 4'd6, 0, 4'd0, 32'h0,    1, 4'd4, 32'hABCD, 32'h22,    32'hABCD};
        vecs[2] = '{32'h0,  0, 4'd9, 32'd3,  1, 4'd0, 4'd9, 1, 4'd9, 32'h1234, 0, 4'd0, 32'h0,    32'h1234,  32'd3};
        vecs[3] = '{32'h0,  0, 4'd5, 32'h0,  0, 4'd5, 4'd1, 1, 4'd5, 32'h111,  1, 4'd5, 32'h222,  32'h222,   32'h222};
        vecs[4] = '{32'h11, 1, 4'd5, 32'h0,  0, 4'd6, 4'd2, 1, 4'd5, 32'h99,   1, 4'd6, 32'h66,   32'h11,    32'h66};
        vecs[5] = '{32'h0,  0, 4'd1, 32'h0,  0, 4'd2, 4'd15, 1, 4'd1, 32'hA,   1, 4'd2, 32'hB,    32'hA,     32'hB};

        idle();
        issue_op = 0; issue_Vj = 0; issue_Rj = 0; issue_Qj = 0; issue_Vk = 0; issue_Rk = 0; issue_Qk = 0;
        issue_Imm = 0; issue_CurPc = 0; issue_RobId = 0;
        alu_cdb_RobId = 0; alu_cdb_value = 0; lsb_cdb_RobId = 0; lsb_cdb_value = 0;

        // Reset, with rdy low and clear high to show reset wins.
        rst = 1; rdy = 0; clear = 1;
        tick();
        chk("reset_alu_enable", 32'(alu_enable), 32'd0);
        chk("reset_rs_full",    32'(rs_full),    32'd0);
        chk("reset_alu_Vj",     alu_Vj,          32'd0);
        idle();
        tick();

        // Vector table: issue with a same-cycle CDB, dispatch exactly 2 cycles later.
        for (int i = 0; i < 6; i++) begin
            set_issue(6'(i), vecs[i].vj, vecs[i].rj, vecs[i].qj, vecs[i].vk, vecs[i].rk, vecs[i].qk, vecs[i].rob);
            alu_cdb_valid = vecs[i].av; alu_cdb_RobId = vecs[i].aid; alu_cdb_value = vecs[i].aval;
            lsb_cdb_valid = vecs[i].lv; lsb_cdb_RobId = vecs[i].lid; lsb_cdb_value = vecs[i].lval;
            tick();
            chk($sformatf("vec%0d_no_early_dispatch", i), 32'(alu_enable), 32'd0);
            idle();
            tick();
            chk($sformatf("vec%0d_enable", i), 32'(alu_enable), 32'd1);
            chk($sformatf("vec%0d_Vj", i),     alu_Vj,          vecs[i].xvj);
            chk($sformatf("vec%0d_Vk", i),     alu_Vk,          vecs[i].xvk);
            chk($sformatf("vec%0d_RobId", i),  32'(alu_RobId),  32'(vecs[i].rob));
            chk($sformatf("vec%0d_op", i),     32'(alu_op),     i);
            chk($sformatf("vec%0d_Imm", i),    alu_Imm,         32'h100 + 32'(vecs[i].rob));
            tick();
            chk($sformatf("vec%0d_drained", i), 32'(alu_enable), 32'd0);
        end

        // CDB wake-up of a stored entry.
        set_issue(6'd1, 32'h0, 0, 4'd2, 32'd1, 1, 4'd0, 4'd8);
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_no_dispatch", 32'(alu_enable), 32'd0);
        end
        alu_cdb_valid = 1; alu_cdb_RobId = 4'd2; alu_cdb_value = 32'h10;
        tick();
        chk("wake_latency", 32'(alu_enable), 32'd0);
        idle();
        tick();
        chk("wake_enable", 32'(alu_enable), 32'd1);
        chk("wake_Vj",     alu_Vj,          32'h10);
        tick();

        // Fill to 15, wake all with one broadcast, drain lowest index first.
        for (int i = 0; i < 15; i++) begin
            set_issue(6'd2, 32'h0, 0, 4'd7, 32'(i), 1, 4'd0, 4'(i));
            tick();
            if (i == 13) chk("fill14_not_full", 32'(rs_full), 32'd0);
        end
        chk("fill15_full", 32'(rs_full), 32'd1);
        idle();
        alu_cdb_valid = 1; alu_cdb_RobId = 4'd7; alu_cdb_value = 32'h77;
        tick();
        idle();
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("drain_enable", 32'(alu_enable), 32'd1);
            chk("drain_order",  32'(alu_RobId),  i);
            chk("drain_Vj",     alu_Vj,          32'h77);
            if (i == 0) chk("drain_full_drop", 32'(rs_full), 32'd0);
        end
        tick();
        chk("drain_done", 32'(alu_enable), 32'd0);

        // Rollback with 5 entries, one ready; issue in the clear cycle is discarded.
        for (int i = 0; i < 4; i++) begin
            set_issue(6'd3, 32'h0, 0, 4'd9, 32'h0, 1, 4'd0, 4'(i));
            tick();
        end
        set_issue(6'd3, 32'h5, 1, 4'd0, 32'h6, 1, 4'd0, 4'd4);
        tick();
        set_issue(6'd3, 32'h1, 1, 4'd0, 32'h2, 1, 4'd0, 4'd5);
        clear = 1;
        tick();
        chk("clear_enable", 32'(alu_enable), 32'd0);
        chk("clear_full",   32'(rs_full),    32'd0);
        idle();
        alu_cdb_valid = 1; alu_cdb_RobId = 4'd9; alu_cdb_value = 32'h9;
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("clear_no_dispatch", 32'(alu_enable), 32'd0);
        end

        // rdy stall while a dispatch is visible and another is pending.
        set_issue(6'd4, 32'hA0, 1, 4'd0, 32'hA1, 1, 4'd0, 4'd10);
        tick();
        set_issue(6'd4, 32'hB0, 1, 4'd0, 32'hB1, 1, 4'd0, 4'd11);
        tick();
        chk("stall_pre_enable", 32'(alu_enable), 32'd1);
        chk("stall_pre_rob",    32'(alu_RobId),  32'd10);
        set_issue(6'd4, 32'hC0, 1, 4'd0, 32'hC1, 1, 4'd0, 4'd12);
        rdy = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_enable", 32'(alu_enable), 32'd1);
            chk("stall_rob",    32'(alu_RobId),  32'd10);
            chk("stall_Vj",     alu_Vj,          32'hA0);
        end
        idle();
        tick();
        chk("resume_rob", 32'(alu_RobId), 32'd11);
        chk("resume_Vk",  alu_Vk,         32'hB1);
        tick();
        chk("resume_done", 32'(alu_enable), 32'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            idle();
            rdy   = ($urandom_range(0, 9) != 0);
            clear = ($urandom_range(0, 49) == 0);
            if (!rs_full && $urandom_range(0, 3) != 0)
                set_issue(6'($urandom_range(0, 6)), $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)),
                          $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), 4'($urandom));
            alu_cdb_valid = ($urandom_range(0, 1) == 1);
            alu_cdb_RobId = 4'($urandom_range(0, 7)); alu_cdb_value = $urandom;
            lsb_cdb_valid = ($urandom_range(0, 2) == 0);
            lsb_cdb_RobId = 4'($urandom_range(0, 7)); lsb_cdb_value = $urandom;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Arithmetic/branch reservation station directly downstream of the issue stage.
- Buffers non-memory micro-ops issued with renamed operands (V/R/Q triples).
- Snoops the two result broadcast buses (ALU and LSB) to wake up waiting operands.
- Dispatches one ready entry per cycle to the ALU, tagged with its ROB id, and flushes all entries on ROB rollback.

Parameters:
- RS_SIZE, 16, number of entries (power of two).
- RS_LOG, 4, log2(RS_SIZE).
- ROB_LOG, 4, ROB index width; config.v default.
- OP_LOG, 6, op-type width; config.v default.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- rdy  in  1  global ready; when low, all state holds.
- clear  in  1  ROB rollback; flush all entries.
- issue_enable  in  1  new micro-op valid this cycle.
- issue_op  in  OP_LOG  op type.
- issue_Vj  in  32  operand 1 value, used when issue_Rj=1.
- issue_Rj  in  1  operand 1 ready (1 = Vj valid).
- issue_Qj  in  ROB_LOG  producer ROB id for operand 1.
- issue_Vk / issue_Rk / issue_Qk  in  32 / 1 / ROB_LOG  operand 2, same encoding as operand 1.
- issue_Imm  in  32  immediate.
- issue_CurPc  in  32  instruction PC.
- issue_RobId  in  ROB_LOG  destination ROB id.
- rs_full  out  1  issue must stall next cycle.
- alu_cdb_valid / alu_cdb_RobId / alu_cdb_value  in  1 / ROB_LOG / 32  ALU broadcast.
- lsb_cdb_valid / lsb_cdb_RobId / lsb_cdb_value  in  1 / ROB_LOG / 32  LSB broadcast.
- alu_enable  out  1  dispatch valid.
- alu_op  out  OP_LOG  dispatched op type.
- alu_Vj / alu_Vk / alu_Imm / alu_CurPc  out  32 each  dispatched operands.
- alu_RobId  out  ROB_LOG  dispatched destination ROB id.

Behaviour:
- Reset (rst=1 at posedge):
  - All entries become invalid.
  - alu_enable=0, rs_full=0.
  - All other alu_* outputs become 0.
  - rst has priority over rdy and clear.
- rdy=0: no register updates, outputs hold. Issue and CDB inputs are ignored that cycle.
- clear=1 (rdy=1):
  - All entries are invalidated.
  - alu_enable=0 next cycle.
  - rs_full=0 next cycle.
  - issue_enable in the same cycle is discarded.
- Allocation:
  - When issue_enable=1, the op is written into the lowest-index free entry.
  - The entry becomes visible at the next posedge.
  - Issuing while no free entry exists is a protocol violation. The op is dropped and the bench flags it.
- Wake-up at allocation: if an operand arrives with R=0 and either CDB broadcasts a matching Q in the same cycle, that operand is stored ready with the CDB value.
- Wake-up of stored entries:
  - Every valid entry with R=0 compares Q against both CDBs each cycle.
  - On a match, V is set to the CDB value and R=1.
  - If both CDBs match, the LSB value is used; this only happens in an illegal duplicate case.
  - The two operands of one entry may wake from different CDBs in the same cycle.
- Dispatch:
  - Eligible entries are valid entries with Rj=1 and Rk=1 as registered at the start of the cycle.
  - The lowest-index eligible entry is selected.
  - Its fields are registered onto alu_* and alu_enable=1 next cycle; the entry is freed at that posedge.
  - When no entry is eligible, alu_enable=0.
  - Latency from operand ready to alu_enable is 1 cycle; issue to earliest dispatch is 2 cycles.
  - The entry being allocated is never dispatched in the same cycle.
- Ordering: no age ordering is required. Correctness relies on ROB commit order.
- rs_full:
  - Registered.
  - Asserted when the post-update occupied count is at least RS_SIZE-1. The one-slot slack covers the combinational issue of the same cycle.
- Simultaneous allocation and dispatch in one cycle are allowed and counted correctly (count unchanged).
- Operand ready-bit encoding: 1 means value valid. Q is don't-care when R=1.

Decomposition:
- config.v:
  - Holds RS_SIZE, RS_LOG, ROB_LOG and OP_LOG.
  - Holds the OP_* encodings shared with the decoder and ALU.
- Sub-module rs_priority_encoder: parameterised lowest-set-bit finder over an RS_SIZE-bit vector, with outputs index and found.
- Two instances are used: one for the free vector, one for the ready vector.

Test Plan:
- Reset, then one ready op: issue ADD Vj=5, Vk=7, RobId=3 with Rj=Rk=1 → alu_enable=1 two cycles later with alu_Vj=5, alu_Vk=7, alu_RobId=3; RS then empty.
- CDB wake-up:
  - Issue op with Rj=0, Qj=2, Rk=1, Vk=1.
  - No dispatch while waiting.
  - ALU CDB broadcasts RobId=2, value=0x10 → dispatch next cycle with alu_Vj=0x10.
- Same-cycle forward: issue with Qk=4, Rk=0 while lsb_cdb broadcasts RobId=4, value=0xABCD → entry stored ready; dispatch 2 cycles after issue with alu_Vk=0xABCD.
- Fill and full:
  - Issue 15 ops that wait on Qj=7 → rs_full=1.
  - One CDB for RobId 7 → all wake, dispatched lowest index first, one per cycle.
  - rs_full deasserts after the first dispatch.
- Rollback: with 5 valid entries and one ready, assert clear → next cycle alu_enable=0, rs_full=0, and no later dispatch.
- rdy stall: hold rdy=0 for 3 cycles during a pending dispatch → outputs frozen; dispatch resumes unchanged after rdy returns high.
